imem_loader: RTL

- Writer-side counterpart of the instruction memory.
- Receives a program as a byte stream through a valid/ready handshake, assembles big-endian 32-bit words, and issues single-cycle write strobes to the instruction memory.
- Holds the CPU in reset until a complete, checksum-verified image has been written.
- Sits between the host/debug byte source and the instruction memory write port.

---
 rtl/imem_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words, writes them to the
// instruction memory and releases the CPU only after the image checksum matches.
module imem_loader #(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             imem_we,
   output logic [31:0]      imem_wa,
   output logic [31:0]      imem_wd,
   output logic             cpu_reset_n,
   output logic             done,
   output logic             error,
   output logic [DEPTH:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [31:0]    MAX_WORDS = 32'(1) << DEPTH;
   localparam logic [DEPTH:0] ONE       = (DEPTH+1)'(1);

   state_t         state, state_next;
   logic [1:0]     byte_cnt;
   logic [23:0]    shift_q;
   logic [31:0]    csum_q;
   logic [DEPTH:0] n_q;
   logic [31:0]    word;
   logic           fire, word_done;
   logic           clear, wr_word;

   assign fire      = byte_valid & byte_ready;
   assign word      = {shift_q, byte_data};
   assign word_done = fire && (byte_cnt == 2'd3);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      clear      = 1'b0;
      wr_word    = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_next = S_HDR;
               clear      = 1'b1;
            end
         end
         S_HDR: begin
            if (word_done)
               state_next = (word == 32'd0 || word > MAX_WORDS) ? S_ERR : S_DATA;
         end
         S_DATA: begin
            if (word_done) begin
               wr_word = 1'b1;
               if (words_loaded + ONE == n_q) state_next = S_CHK;
            end
         end
         S_CHK: begin
            if (word_done) state_next = (word == csum_q) ? S_DONE : S_ERR;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: status outputs are decoded from state_next into flops, so they change
   // on the same edge as the state and stay glitch-free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_ready   <= 1'b0;
         imem_we      <= 1'b0;
         imem_wa      <= '0;
         imem_wd      <= '0;
         cpu_reset_n  <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         byte_cnt     <= '0;
         shift_q      <= '0;
         csum_q       <= '0;
         n_q          <= '0;
      end else begin
         byte_ready  <= (state_next == S_HDR) || (state_next == S_DATA) || (state_next == S_CHK);
         done        <= (state_next == S_DONE);
         error       <= (state_next == S_ERR);
         cpu_reset_n <= (state_next == S_DONE);
         imem_we     <= wr_word;

         if (clear) begin
            words_loaded <= '0;
            csum_q       <= '0;
            byte_cnt     <= '0;
         end

         if (fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= word[23:0];
         end

         if (state == S_HDR && word_done) n_q <= word[DEPTH:0];

         // Address uses the pre-increment count, so word k lands at byte address k*4.
         if (wr_word) begin
            imem_wa      <= {{(29-DEPTH){1'b0}}, words_loaded, 2'b00};
            imem_wd      <= word;
            words_loaded <= words_loaded + ONE;
            csum_q       <= csum_q ^ word;
         end
      end
   end

endmodule
